// File: rtl/spike_delay_line.sv
// Delays each rising edge of an asynchronous spike input by a programmable number of
// cycles and re-emits it as a single-cycle pulse; in-flight spikes are queued as due-times.
module spike_delay_line #(
    parameter int DEPTH_LOG2 = 6,
    parameter int CNT_W      = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spike_in,
    input  logic [CNT_W-1:0]      delay_cycles,
    output logic                  spike_out,
    output logic [DEPTH_LOG2:0]   pending,
    output logic [15:0]           drop_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]        T_ONE      = {{CNT_W{1'b0}}, 1'b1};

    logic                  sync1;
    logic                  sync2;
    logic                  sync3;
    logic                  accept;
    logic [CNT_W:0]        t;
    logic [CNT_W:0]        t_next;
    logic [CNT_W:0]        due_new;
    logic [CNT_W:0]        head_due;
    logic [CNT_W:0]        head_age;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [CNT_W:0]        mem [DEPTH];
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign t_next   = t + T_ONE;
    // The due-time is referenced to the cycle in which the new entry is first visible,
    // which gives delay_cycles + 4 edges from the first high sample to the pulse.
    assign due_new  = t_next + {1'b0, delay_cycles};
    assign head_due = mem[rd_ptr];
    assign head_age = t - head_due;
    // Age MSB clear means t has reached or passed the head's due-time (wrap-safe).
    assign pop      = (count != '0) && !head_age[CNT_W];
    assign full     = (count == FULL_COUNT);
    assign push     = accept && (!full || pop);
    assign drop     = accept && full && !pop;
    assign pending  = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            accept    <= 1'b0;
            t         <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            spike_out <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            sync1     <= spike_in;
            sync2     <= sync1;
            sync3     <= sync2;
            accept    <= sync2 & ~sync3;
            t         <= t_next;
            spike_out <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Storage carries no reset; entries are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= due_new;
        end
    end

endmodule

// File: tb/tb_spike_delay_line.sv
// Bench for spike_delay_line: table of single-spike latencies, directed buffer-full,
// delay-change, wrap and reset sequences, and randomized traffic against an edge-count model.
module tb_spike_delay_line;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spike_in = 1'b0;
    logic [17:0] delay_cycles = '0;
    logic        spike_out;
    logic [6:0]  pending;
    logic [15:0] drop_cnt;

    logic        spike_in_w = 1'b0;
    logic [3:0]  delay_w = '0;
    logic        spike_out_w;
    logic [6:0]  pending_w;
    logic [15:0] drop_cnt_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spike_delay_line dut (
        .clk          (clk),
        .reset        (reset),
        .spike_in     (spike_in),
        .delay_cycles (delay_cycles),
        .spike_out    (spike_out),
        .pending      (pending),
        .drop_cnt     (drop_cnt)
    );

    spike_delay_line #(.DEPTH_LOG2(6), .CNT_W(4)) dut_w (
        .clk          (clk),
        .reset        (reset),
        .spike_in     (spike_in_w),
        .delay_cycles (delay_w),
        .spike_out    (spike_out_w),
        .pending      (pending_w),
        .drop_cnt     (drop_cnt_w)
    );

    // Reference model in absolute edge numbers: a rise sampled at edge n is queued at
    // edge n+3, released at max(n+d+4, previous release+1), capacity 64 entries.
    int          cyc = 0;
    bit          prev = 1'b0;
    bit          prev_w = 1'b0;
    int          push_q[$];
    logic [31:0] exp_q[$];
    bit          exp_out = 1'b0;
    int          exp_pending = 0;
    int          exp_drop = 0;
    int          in_q[$];
    int          in_w_q[$];
    int          out_q[$];
    int          out_w_q[$];
    int          peak = 0;

    always @(posedge clk or posedge reset) begin
        int due;
        if (reset) begin
            prev = 1'b0;
            prev_w = 1'b0;
            push_q.delete();
            exp_q.delete();
            exp_out = 1'b0;
            exp_pending = 0;
            exp_drop = 0;
        end else begin
            cyc++;
            if (spike_in && !prev) begin
                in_q.push_back(cyc);
                push_q.push_back(cyc + 3);
            end
            prev = spike_in;
            if (spike_in_w && !prev_w) in_w_q.push_back(cyc);
            prev_w = spike_in_w;
            exp_out = 1'b0;
            if (exp_q.size() != 0 && int'(exp_q[0]) == cyc) begin
                exp_out = 1'b1;
                void'(exp_q.pop_front());
            end
            if (push_q.size() != 0 && push_q[0] == cyc) begin
                void'(push_q.pop_front());
                if (exp_q.size() < 64) begin
                    due = cyc + 1 + int'(delay_cycles);
                    if (exp_q.size() != 0 && int'(exp_q[$]) >= due) due = int'(exp_q[$]) + 1;
                    exp_q.push_back(due);
                end else if (exp_drop < 65535) begin
                    exp_drop++;
                end
            end
            exp_pending = exp_q.size();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (spike_out) out_q.push_back(cyc);
        if (spike_out_w) out_w_q.push_back(cyc);
        if (int'(pending) > peak) peak = int'(pending);
        check("model_spike_out", int'(spike_out), int'(exp_out));
        check("model_pending", int'(pending), exp_pending);
        check("model_drop_cnt", int'(drop_cnt), exp_drop);
    endtask

    task automatic pulse(input int width, input int gap);
        spike_in = 1'b1;
        repeat (width) tick();
        spike_in = 1'b0;
        repeat (gap) tick();
    endtask

    typedef struct {
        int delay;
        int width;
        int exp_lat;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int bi, bo;

        vecs[0] = '{delay: 100, width: 3,  exp_lat: 104};
        vecs[1] = '{delay: 0,   width: 50, exp_lat: 4};
        vecs[2] = '{delay: 1,   width: 1,  exp_lat: 5};
        vecs[3] = '{delay: 7,   width: 2,  exp_lat: 11};
        vecs[4] = '{delay: 37,  width: 5,  exp_lat: 41};
        vecs[5] = '{delay: 255, width: 1,  exp_lat: 259};

        repeat (3) tick();
        check("reset_spike_out", int'(spike_out), 0);
        check("reset_pending", int'(pending), 0);
        check("reset_drop_cnt", int'(drop_cnt), 0);
        #2 reset = 1'b0;
        repeat (2) tick();

        // Single spikes: one pulse each, at delay + 4 edges, pending never above 1.
        for (int i = 0; i < 6; i++) begin
            delay_cycles = 18'(vecs[i].delay);
            bi = in_q.size();
            bo = out_q.size();
            peak = 0;
            pulse(vecs[i].width, vecs[i].exp_lat + 12);
            check("tbl_pulse_count", out_q.size() - bo, 1);
            if (out_q.size() > bo && in_q.size() > bi)
                check("tbl_latency", out_q[bo] - in_q[bi], vecs[i].exp_lat);
            check("tbl_peak_pending", peak, 1);
        end
        check("tbl_drop_cnt", int'(drop_cnt), 0);

        // Buffer overflow: 70 spikes, 64 held, 6 dropped.
        delay_cycles = 18'd1000;
        bi = in_q.size();
        bo = out_q.size();
        peak = 0;
        repeat (70) pulse(2, 2);
        repeat (1100) tick();
        check("full_peak_pending", peak, 64);
        check("full_drop_cnt", int'(drop_cnt), 6);
        check("full_pulse_count", out_q.size() - bo, 64);
        for (int i = 0; i < 64 && bo + i < out_q.size(); i++)
            check("full_latency", out_q[bo + i] - in_q[bi + i], 1004);

        // Delay shortened behind a backlog: fourth spike follows third on the next cycle.
        delay_cycles = 18'd200;
        bi = in_q.size();
        bo = out_q.size();
        repeat (3) pulse(2, 4);
        repeat (4) tick();
        delay_cycles = 18'd10;
        pulse(2, 4);
        repeat (260) tick();
        check("chg_pulse_count", out_q.size() - bo, 4);
        if (out_q.size() >= bo + 4) begin
            check("chg_first_latency", out_q[bo] - in_q[bi], 204);
            check("chg_back_to_back", out_q[bo + 3] - out_q[bo + 2], 1);
        end

        // Randomized traffic with the delay changing between spikes.
        repeat (60) begin
            delay_cycles = 18'($urandom_range(0, 40));
            pulse($urandom_range(1, 4), $urandom_range(1, 8));
        end
        repeat (80) tick();
        check("rand_drained", int'(pending), 0);

        // Timestamp wrap on the narrow instance: 40 spikes, each at 19 edges.
        delay_w = 4'd15;
        bi = in_w_q.size();
        bo = out_w_q.size();
        repeat (40) begin
            spike_in_w = 1'b1;
            repeat (2) tick();
            spike_in_w = 1'b0;
            repeat (6) tick();
        end
        repeat (30) tick();
        check("wrap_pulse_count", out_w_q.size() - bo, 40);
        for (int i = 0; i < 40 && bo + i < out_w_q.size() && bi + i < in_w_q.size(); i++)
            check("wrap_latency", out_w_q[bo + i] - in_w_q[bi + i], 19);
        check("wrap_drop_cnt", int'(drop_cnt_w), 0);

        // Asynchronous reset with five spikes in flight.
        delay_cycles = 18'd100;
        repeat (5) pulse(2, 4);
        repeat (6) tick();
        check("rst_pending_before", int'(pending), 5);
        #2 reset = 1'b1;
        #1;
        check("rst_async_spike_out", int'(spike_out), 0);
        check("rst_async_pending", int'(pending), 0);
        check("rst_async_drop_cnt", int'(drop_cnt), 0);
        bo = out_q.size();
        repeat (2) tick();
        #2 reset = 1'b0;
        repeat (300) tick();
        check("rst_no_output", out_q.size() - bo, 0);
        check("rst_pending_after", int'(pending), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
